// File: rtl/mem_pkg.sv
// Shared types and sizes for the memory request controller slice.
package mem_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;  // must equal 2**ADDR_W

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RSP  = 3'd3,
    CLR  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, cleared synchronously.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: advance only when not already at the ceiling.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// Request-side controller for the 8x8 negedge memory: serialises single-beat
// read/write requests onto the memory port, returns read data on a response
// channel, and runs a one-shot clear of every location.
//
// Handshakes: a transfer happens on a posedge where valid and ready are both
// high; valid, once raised by a producer, is held with its payload stable
// until that edge, and ready never depends on valid.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [2:0]        dbg_state
);

  ctrl_state_t state_q, state_d;
  logic        mem_op_q, mem_op_d;
  addr_t       mem_addr_q, mem_addr_d;
  data_t       mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  data_t       rsp_rdata_q, rsp_rdata_d;
  addr_t       rsp_addr_q, rsp_addr_d;
  addr_t       clr_ptr_q, clr_ptr_d;
  logic        wr_inc;
  logic        rd_inc;

  // Next-state and registered memory-port values for every controller state.
  always_comb begin
    state_d     = state_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_addr_d  = rsp_addr_q;
    clr_ptr_d   = clr_ptr_q;
    wr_inc      = 1'b0;
    rd_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        // Idle cycles present a harmless read to the memory.
        mem_op_d = 1'b0;
        if (clear_start) begin
          // Clear wins over a simultaneous request.
          state_d     = CLR;
          clr_ptr_d   = '0;
          mem_op_d    = 1'b1;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end else if (req_valid && req_we) begin
          state_d     = WR;
          mem_op_d    = 1'b1;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata;
          wr_inc      = 1'b1;
        end else if (req_valid) begin
          state_d    = RD;
          mem_addr_d = req_addr;
          rsp_addr_d = req_addr;
        end
      end
      WR: begin
        // The memory has committed the write at the mid-cycle negedge.
        mem_op_d = 1'b0;
        state_d  = IDLE;
      end
      RD: begin
        // mem_rdata was refreshed at the mid-cycle negedge.
        rsp_rdata_d = mem_rdata;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rd_inc      = 1'b1;
          state_d     = IDLE;
        end
      end
      CLR: begin
        if (clr_ptr_q != addr_t'(DEPTH - 1)) begin
          clr_ptr_d   = clr_ptr_q + addr_t'(1);
          mem_addr_d  = clr_ptr_q + addr_t'(1);
          mem_wdata_d = '0;
          mem_op_d    = 1'b1;
        end else begin
          mem_op_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_op_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_op_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
      clr_ptr_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_addr_q  <= rsp_addr_d;
      clr_ptr_q   <= clr_ptr_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (wr_inc),
    .count (wr_cnt)
  );

  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (rd_inc),
    .count (rd_cnt)
  );

  assign req_ready  = (state_q == IDLE) && !clear_start;
  assign clear_busy = (state_q == CLR);
  assign mem_op     = mem_op_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_addr   = rsp_addr_q;
  assign dbg_state  = state_q;

endmodule
